// File: rtl/loop_counter_pkg.sv
// Shared types and constants for the loop-count register and its decrementer.
package loop_counter_pkg;

   localparam int LC_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      EXPIRED = 2'b10
   } lc_state_t;

endpackage

// File: rtl/loop_counter_subByOne.sv
// Fixed-width 16-bit decrementer; modulo-2^16 subtract of one.
import loop_counter_pkg::*;

module subByOne (
   input  logic [LC_WIDTH-1:0] i_a,
   output logic [LC_WIDTH-1:0] o_y
);

   assign o_y = i_a - LC_WIDTH'(1);

endmodule

// File: rtl/loop_counter.sv
// Loop-count register for decrement-and-branch-if-not-zero: holds the count,
// steps it through subByOne and reports branch-taken, zero and underflow.
import loop_counter_pkg::*;

module loop_counter #(
   parameter int WIDTH = LC_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec_en,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             taken,
   output logic             underflow
);

   lc_state_t        r_state;
   lc_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_dec;
   logic             r_taken;
   logic             w_taken_nxt;
   logic             r_underflow;
   logic             w_underflow_nxt;

   subByOne u_sub (
      .i_a (r_count),
      .o_y (w_dec)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_taken_nxt     = 1'b0;
      w_underflow_nxt = r_underflow;
      if (load_en) begin
         // Load wins over a same-cycle decrement, which is silently dropped.
         w_count_nxt     = load_val;
         w_underflow_nxt = 1'b0;
         w_state_nxt     = (load_val != '0) ? ARMED : EXPIRED;
      end else begin
         case (r_state)
            ARMED: begin
               if (dec_en) begin
                  w_count_nxt = w_dec;
                  if (w_dec != '0) w_taken_nxt = 1'b1;
                  else             w_state_nxt = EXPIRED;
               end
            end
            IDLE, EXPIRED: begin
               if (dec_en) w_underflow_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_taken     <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_taken     <= w_taken_nxt;
         r_underflow <= w_underflow_nxt;
      end
   end

   assign count     = r_count;
   assign zero      = (r_count == '0);
   assign taken     = r_taken;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_loop_counter.sv
// Directed self-checking bench for loop_counter.
module tb_loop_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [15:0] load_val;
   logic        dec_en;
   logic [15:0] count;
   logic        zero;
   logic        taken;
   logic        underflow;

   int n_checks = 0;
   int n_fail   = 0;

   loop_counter #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .load_val  (load_val),
      .dec_en    (dec_en),
      .count     (count),
      .zero      (zero),
      .taken     (taken),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      load_en = 1'b1; load_val = v; dec_en = 1'b0;
      step();
      load_en = 1'b0;
   endtask

   task automatic do_dec();
      dec_en = 1'b1;
      step();
      dec_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_en = 1'b0; load_val = '0; dec_en = 1'b0;
      #12;
      n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h exp 0000", count); end
      n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b exp 1", zero); end
      n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b exp 0", taken); end
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b exp 0", underflow); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_count3();
      logic [15:0] exp_c [3] = '{16'd2, 16'd1, 16'd0};
      logic        exp_t [3] = '{1'b1, 1'b1, 1'b0};
      do_load(16'd3);
      n_checks++; if (count !== 16'd3 || zero !== 1'b0) begin n_fail++; $display("FAIL load3: got count %h zero %b exp 0003 0", count, zero); end
      dec_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (count !== exp_c[i]) begin n_fail++; $display("FAIL dec3_count[%0d]: got %h exp %h", i, count, exp_c[i]); end
         n_checks++; if (taken !== exp_t[i]) begin n_fail++; $display("FAIL dec3_taken[%0d]: got %b exp %b", i, taken, exp_t[i]); end
         n_checks++; if (zero !== (i == 2)) begin n_fail++; $display("FAIL dec3_zero[%0d]: got %b exp %b", i, zero, (i == 2)); end
         n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL dec3_underflow[%0d]: got %b exp 0", i, underflow); end
      end
      dec_en = 1'b0;
      do_dec();
      n_checks++; if (count !== 16'h0000 || underflow !== 1'b1 || taken !== 1'b0) begin n_fail++; $display("FAIL expired_dec: got count %h uf %b taken %b exp 0000 1 0", count, underflow, taken); end
   endtask

   task automatic test_underflow_idle();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL async_clear_uf: got %b exp 0", underflow); end
      step();
      rst_n = 1'b1;
      do_dec();
      n_checks++; if (count !== 16'h0000 || underflow !== 1'b1 || taken !== 1'b0) begin n_fail++; $display("FAIL idle_dec: got count %h uf %b taken %b exp 0000 1 0", count, underflow, taken); end
      step();
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b exp 1", underflow); end
      do_load(16'd7);
      n_checks++; if (underflow !== 1'b0 || count !== 16'd7) begin n_fail++; $display("FAIL load7_clear: got uf %b count %h exp 0 0007", underflow, count); end
   endtask

   task automatic test_reset_midloop();
      do_load(16'd5);
      dec_en = 1'b1;
      step();
      step();
      dec_en = 1'b0;
      n_checks++; if (count !== 16'd3 || taken !== 1'b1) begin n_fail++; $display("FAIL midloop_pre: got count %h taken %b exp 0003 1", count, taken); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 16'h0000 || zero !== 1'b1 || taken !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midloop_reset: got count %h zero %b taken %b uf %b exp 0000 1 0 0", count, zero, taken, underflow); end
      step();
      rst_n = 1'b1;
      do_dec();
      n_checks++; if (count !== 16'h0000 || underflow !== 1'b1) begin n_fail++; $display("FAIL midloop_idle_dec: got count %h uf %b exp 0000 1", count, underflow); end
   endtask

   task automatic test_load_zero();
      do_load(16'h0000);
      n_checks++; if (zero !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL load0: got zero %b uf %b exp 1 0", zero, underflow); end
      do_dec();
      n_checks++; if (underflow !== 1'b1 || taken !== 1'b0 || count !== 16'h0000) begin n_fail++; $display("FAIL load0_dec: got uf %b taken %b count %h exp 1 0 0000", underflow, taken, count); end
   endtask

   task automatic test_boundary();
      do_load(16'hFFFF);
      do_dec();
      n_checks++; if (count !== 16'hFFFE || taken !== 1'b1) begin n_fail++; $display("FAIL ffff_dec: got count %h taken %b exp fffe 1", count, taken); end
      step();
      n_checks++; if (taken !== 1'b0 || count !== 16'hFFFE) begin n_fail++; $display("FAIL taken_pulse: got taken %b count %h exp 0 fffe", taken, count); end
      do_load(16'h0001);
      do_dec();
      n_checks++; if (count !== 16'h0000 || taken !== 1'b0 || zero !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL one_dec: got count %h taken %b zero %b uf %b exp 0000 0 1 0", count, taken, zero, underflow); end
   endtask

   task automatic test_simultaneous();
      do_load(16'd9);
      load_en = 1'b1; load_val = 16'd4; dec_en = 1'b1;
      step();
      load_en = 1'b0; dec_en = 1'b0;
      n_checks++; if (count !== 16'd4 || taken !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL load_dec_same: got count %h taken %b uf %b exp 0004 0 0", count, taken, underflow); end
      do_dec();
      n_checks++; if (count !== 16'd3 || taken !== 1'b1) begin n_fail++; $display("FAIL after_simul_dec: got count %h taken %b exp 0003 1", count, taken); end
   endtask

   initial begin
      test_reset();
      test_count3();
      test_underflow_idle();
      test_reset_midloop();
      test_load_zero();
      test_boundary();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
